// File: rtl/tag_free_list.sv
// Free list of physical register tags: a circular FIFO of free tags, plus an
// in-list bitmap that rejects double frees. It is refilled from ROB retirement
// and drained by rename.
module tag_free_list #(
  parameter  int NUM_TAGS       = 64,
  parameter  int FIRST_FREE_TAG = 32,
  localparam int TAG_W          = $clog2(NUM_TAGS),
  localparam int CNT_W          = $clog2(NUM_TAGS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [TAG_W-1:0] freed_tag_1,
  input  logic [TAG_W-1:0] freed_tag_2,
  input  logic             alloc_req,
  output logic             alloc_valid,
  output logic [TAG_W-1:0] alloc_tag,
  output logic [CNT_W-1:0] free_count,
  output logic             error
);

  localparam int NUM_FREE = NUM_TAGS - FIRST_FREE_TAG;

  typedef logic [NUM_TAGS-1:0][TAG_W-1:0] list_t;

  list_t                mem_q,    mem_d;
  logic [NUM_TAGS-1:0]  bitmap_q, bitmap_d;
  logic [TAG_W-1:0]     head_q,   head_d;
  logic [TAG_W-1:0]     tail_q,   tail_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic                 error_q,  error_d;

  logic                 do_pop;
  logic                 t1_nz, t2_nz;
  logic                 t1_dup, t2_dup;
  logic                 push1, push2;
  logic                 t1_ovf, t2_ovf;
  logic [CNT_W:0]       room, room2;

  // Pointer advance modulo NUM_TAGS; does not rely on NUM_TAGS being a power of two.
  function automatic logic [TAG_W-1:0] ptr_add(input logic [TAG_W-1:0] p,
                                                input logic [1:0]       inc);
    logic [TAG_W:0] s;
    s = {1'b0, p} + (TAG_W + 1)'(inc);
    if (s >= (TAG_W + 1)'(NUM_TAGS))
      s = s - (TAG_W + 1)'(NUM_TAGS);
    return s[TAG_W-1:0];
  endfunction

  function automatic list_t reset_list();
    list_t r;
    for (int i = 0; i < NUM_TAGS; i++)
      r[i] = (i < NUM_FREE) ? TAG_W'(FIRST_FREE_TAG + i) : '0;
    return r;
  endfunction

  function automatic logic [NUM_TAGS-1:0] reset_bitmap();
    logic [NUM_TAGS-1:0] r;
    for (int t = 0; t < NUM_TAGS; t++)
      r[t] = (t >= FIRST_FREE_TAG);
    return r;
  endfunction

  always_comb begin
    do_pop = alloc_req && (count_q != '0);
    t1_nz  = (freed_tag_1 != '0);
    t2_nz  = (freed_tag_2 != '0);
    t1_dup = t1_nz && bitmap_q[freed_tag_1];
    // When both ports free the same tag, only port 1's copy can get in.
    t2_dup = t2_nz && (bitmap_q[freed_tag_2] || (freed_tag_2 == freed_tag_1));

    // Free slots after this cycle's pop, handed out to port 1 first.
    room   = (CNT_W + 1)'(NUM_TAGS) - {1'b0, count_q} + (CNT_W + 1)'(do_pop);
    push1  = t1_nz && !t1_dup && (room != '0);
    t1_ovf = t1_nz && !t1_dup && (room == '0);
    room2  = room - (CNT_W + 1)'(push1);
    push2  = t2_nz && !t2_dup && (room2 != '0);
    t2_ovf = t2_nz && !t2_dup && (room2 == '0);

    mem_d    = mem_q;
    bitmap_d = bitmap_q;
    if (do_pop)
      bitmap_d[mem_q[head_q]] = 1'b0;
    if (push1) begin
      mem_d[tail_q]         = freed_tag_1;
      bitmap_d[freed_tag_1] = 1'b1;
    end
    if (push2) begin
      mem_d[ptr_add(tail_q, {1'b0, push1})] = freed_tag_2;
      bitmap_d[freed_tag_2]                 = 1'b1;
    end

    head_d  = ptr_add(head_q, {1'b0, do_pop});
    tail_d  = ptr_add(tail_q, {1'b0, push1} + {1'b0, push2});
    count_d = count_q - CNT_W'(do_pop) + CNT_W'(push1) + CNT_W'(push2);
    error_d = error_q | (alloc_req && !do_pop) | t1_dup | t2_dup | t1_ovf | t2_ovf;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= reset_list();
      bitmap_q <= reset_bitmap();
      head_q   <= '0;
      tail_q   <= TAG_W'(NUM_FREE % NUM_TAGS);
      count_q  <= CNT_W'(NUM_FREE);
      error_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      bitmap_q <= bitmap_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  // The head entry is presented directly, so a freshly pushed tag appears only after the edge.
  assign alloc_valid = (count_q != '0);
  assign alloc_tag   = alloc_valid ? mem_q[head_q] : '0;
  assign free_count  = count_q;
  assign error       = error_q;

endmodule
